// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: ALU opcodes, command ops, FSM states.
package alu_seq_pkg;

   // Opcodes understood by the attached combinational ALU
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // Command opcodes accepted on the command channel
   typedef enum logic [2:0] {
      CMD_ADD  = 3'b000,
      CMD_SUB  = 3'b001,
      CMD_AND  = 3'b010,
      CMD_OR   = 3'b011,
      CMD_MUL  = 3'b100,
      CMD_EQ   = 3'b101,
      CMD_RSV0 = 3'b110,
      CMD_RSV1 = 3'b111
   } cmd_op_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_EXEC     = 2'b01,
      ST_MUL_LOOP = 2'b10,
      ST_RESP     = 2'b11
   } seq_state_e;

endpackage : alu_seq_pkg

// File: rtl/alu_cmd_sequencer.sv
// Initiator for an external combinational ALU. Accepts commands over valid/ready,
// drives registered operands/opcode to the ALU, and returns the captured result
// over a valid/ready response channel. MUL is done by repeated ADD, EQ via SUB.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_a,
   input  logic [DATA_WIDTH-1:0] cmd_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_zero,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] alu_data_rs1,
   output logic [DATA_WIDTH-1:0] alu_source_2,
   output logic [1:0]            alu_inst,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero
);

   localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ONE_W  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   seq_state_e            state_q;
   // The rs1 register doubles as the MUL accumulator: each loop pass feeds the
   // running sum straight back into operand 1.
   logic [DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] src2_q;
   logic [1:0]            inst_q;
   logic [DATA_WIDTH-1:0] cnt_q;
   logic                  err_q;
   logic                  is_eq_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_result_q;
   logic                  rsp_zero_q;
   logic                  rsp_err_q;

   assign cmd_ready    = (state_q == ST_IDLE);
   assign rsp_valid    = rsp_valid_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_zero     = rsp_zero_q;
   assign rsp_err      = rsp_err_q;
   assign alu_data_rs1 = acc_q;
   assign alu_source_2 = src2_q;
   assign alu_inst     = inst_q;

   // Sequencer FSM: command decode, ALU drive, MUL loop and response handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         acc_q        <= ZERO_W;
         src2_q       <= ZERO_W;
         inst_q       <= ALU_ADD;
         cnt_q        <= ZERO_W;
         err_q        <= 1'b0;
         is_eq_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= ZERO_W;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  err_q   <= 1'b0;
                  is_eq_q <= 1'b0;
                  case (cmd_op_e'(cmd_op))
                     CMD_ADD, CMD_SUB, CMD_AND, CMD_OR: begin
                        acc_q   <= cmd_a;
                        src2_q  <= cmd_b;
                        inst_q  <= cmd_op[1:0];
                        state_q <= ST_EXEC;
                     end
                     CMD_EQ: begin
                        // Equality is a subtraction judged by the zero flag
                        acc_q   <= cmd_a;
                        src2_q  <= cmd_b;
                        inst_q  <= ALU_SUB;
                        is_eq_q <= 1'b1;
                        state_q <= ST_EXEC;
                     end
                     CMD_MUL: begin
                        if (cmd_b == ZERO_W) begin
                           // Nothing to accumulate: a AND 0 yields 0 in one pass
                           acc_q   <= cmd_a;
                           src2_q  <= ZERO_W;
                           inst_q  <= ALU_AND;
                           state_q <= ST_EXEC;
                        end else begin
                           acc_q   <= ZERO_W;
                           src2_q  <= cmd_a;
                           inst_q  <= ALU_ADD;
                           cnt_q   <= cmd_b;
                           state_q <= ST_MUL_LOOP;
                        end
                     end
                     default: begin
                        // Reserved op: harmless AND 0,0 and flag the error
                        acc_q   <= ZERO_W;
                        src2_q  <= ZERO_W;
                        inst_q  <= ALU_AND;
                        err_q   <= 1'b1;
                        state_q <= ST_EXEC;
                     end
                  endcase
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               if (is_eq_q) begin
                  rsp_result_q <= {{(DATA_WIDTH-1){1'b0}}, alu_zero};
                  rsp_zero_q   <= ~alu_zero;
               end else begin
                  rsp_result_q <= alu_result;
                  rsp_zero_q   <= alu_zero;
               end
               rsp_err_q   <= err_q;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_MUL_LOOP: begin
               acc_q <= alu_result;
               cnt_q <= cnt_q - ONE_W;
               if (cnt_q == ONE_W) begin
                  rsp_result_q <= alu_result;
                  rsp_zero_q   <= alu_zero;
                  rsp_err_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  state_q <= ST_MUL_LOOP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  // Result and zero flag stay visible after the handshake
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  state_q <= ST_RESP;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : alu_cmd_sequencer
